// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//
// Pipelined two's-complement adder. A WIDTH-bit addition is split into STAGES
// equal ripple chunks of CHUNK = WIDTH/STAGES bits. Each pipeline stage adds
// one chunk, and the carry between chunks is registered from stage to stage.
// Operand chunks that have not been added yet travel forward in skew
// registers. Sum chunks that are already finished travel forward alongside
// them. The last stage's registers drive the outputs directly.
//
// Handshake: the whole pipe advances together when adv = !out_valid ||
// out_ready. in_ready equals adv, so it is combinational from out_ready.
// Bubbles are kept in the pipe and are not collapsed.
//
// Optional feature macro: PIPELINED_ADDER_SUB_EN
//   When it is defined, the port 'sub' exists. With sub = 1 the block computes
//   a - b as a + ~b + 1, and c_in is ignored.
//   When it is undefined, the block performs addition only.
//
// Parameters:
//   WIDTH   operand and sum width; must be a multiple of STAGES
//   STAGES  pipeline depth (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   block can accept operands this cycle
//   a, b       operands
//   c_in       carry into bit 0
//   sub        subtract select (only with PIPELINED_ADDER_SUB_EN)
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   sum        result
//   c_out      carry out of bit WIDTH-1 (1 = no borrow when subtracting)
//   ovf        signed overflow (carry into the MSB xor carry out of the MSB)
// -----------------------------------------------------------------------------
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;
    // Number of skew register sets between stages. A single-stage build keeps
    // one dummy set so that the array declarations stay legal.
    localparam int SKEW  = (STAGES > 1) ? STAGES - 1 : 1;

    // This adds one chunk and returns {carry into chunk MSB, carry out, sum}.
    // The carry into the MSB is recovered as sum_msb ^ x_msb ^ y_msb.
    function automatic logic [CHUNK+1:0] add_chunk(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             ci
    );
        logic [CHUNK:0] t;
        t = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
        return {t[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1], t};
    endfunction

    // Skew/partial-result registers: entry s is the output of stage s.
    logic [WIDTH-1:0] r_a   [SKEW];
    logic [WIDTH-1:0] r_b   [SKEW];
    logic [WIDTH-1:0] r_sum [SKEW];
    logic             r_cy  [SKEW];

    // Per-stage valid bits. Bit STAGES-1 is out_valid.
    logic [STAGES-1:0] r_vld;
    logic [WIDTH-1:0]  r_sum_o;
    logic              r_c_out;
    logic              r_ovf;

    logic              w_adv;
    logic [STAGES-1:0] w_vin;
    logic [WIDTH-1:0]  w_b0;
    logic              w_ci0;
    logic [CHUNK+1:0]  w_res [STAGES];
    logic [WIDTH-1:0]  w_sum [STAGES];
    logic              w_co  [STAGES];
    logic              w_cm  [STAGES];

    assign w_adv    = !r_vld[STAGES-1] || out_ready;
    assign in_ready = w_adv;
    // Valid bit entering each stage on an advance. The oldest bit falls off.
    assign w_vin    = STAGES'({r_vld, in_valid});

    // Subtraction is folded into stage 0: ~b is stored in the skew chain, so
    // later stages see a plain addition.
    always_comb begin
`ifdef PIPELINED_ADDER_SUB_EN
        w_b0  = sub ? ~b : b;
        w_ci0 = sub ? 1'b1 : c_in;
`else
        w_b0  = b;
        w_ci0 = c_in;
`endif
    end

    always_comb begin
        w_res[0] = add_chunk(a[CHUNK-1:0], w_b0[CHUNK-1:0], w_ci0);
        w_sum[0] = '0;
        w_sum[0][CHUNK-1:0] = w_res[0][CHUNK-1:0];
        w_co[0]  = w_res[0][CHUNK];
        w_cm[0]  = w_res[0][CHUNK+1];
        for (int s = 1; s < STAGES; s++) begin
            w_res[s] = add_chunk(r_a[s-1][s*CHUNK +: CHUNK],
                                 r_b[s-1][s*CHUNK +: CHUNK],
                                 r_cy[s-1]);
            w_sum[s] = r_sum[s-1];
            w_sum[s][s*CHUNK +: CHUNK] = w_res[s][CHUNK-1:0];
            w_co[s]  = w_res[s][CHUNK];
            w_cm[s]  = w_res[s][CHUNK+1];
        end
    end

    // ---- stage boundaries 0..STAGES-2: skew data (no reset; bubbles are don't-care)
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_a[0]   <= a;
            r_b[0]   <= w_b0;
            r_sum[0] <= w_sum[0];
            r_cy[0]  <= w_co[0];
            for (int s = 1; s < STAGES - 1; s++) begin
                r_a[s]   <= r_a[s-1];
                r_b[s]   <= r_b[s-1];
                r_sum[s] <= w_sum[s];
                r_cy[s]  <= w_co[s];
            end
        end
    end

    // ---- last stage boundary: valid chain and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= '0;
            r_sum_o <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_adv) begin
            r_vld <= w_vin;
            // The outputs hold the last real result; bubbles leave them untouched.
            if (w_vin[STAGES-1]) begin
                r_sum_o <= w_sum[STAGES-1];
                r_c_out <= w_co[STAGES-1];
                r_ovf   <= w_cm[STAGES-1] ^ w_co[STAGES-1];
            end
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign sum       = r_sum_o;
    assign c_out     = r_c_out;
    assign ovf       = r_ovf;

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

- Parametrised, pipelined two's-complement adder.
- Splits a WIDTH-bit addition into STAGES equal carry-ripple chunks, one chunk per pipeline stage, with the inter-chunk carry registered between stages.
- Replaces the fixed 4-bit combinational ripple adder wherever operand width or clock rate exceeds a single ripple path.
- Valid/ready handshake on both sides; sits between operand-producing and result-consuming datapath blocks.

## Interface
- WIDTH, 16: operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4: pipeline depth. Each stage adds CHUNK = WIDTH/STAGES bits. STAGES >= 1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry into bit 0.
- sub  input  1  subtract select. Present only with PIPELINED_ADDER_SUB_EN.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: the carry into the MSB XOR the carry out of the MSB.

## Operation
- Stage s (0..STAGES-1) adds chunk s of A and B plus the carry registered from stage s-1. Stage 0 uses c_in.
- Higher chunks not yet added travel forward in skew registers. Lower chunks of the sum already produced travel forward as well.
- Each stage holds a valid bit. The last stage's registers drive sum, c_out, ovf and out_valid directly; there is no combinational path from inputs to outputs.
- Global advance: adv = !out_valid || out_ready. All stages shift when adv = 1; otherwise they hold.
- in_ready = adv. This path is combinational from out_ready.
- Transfer in occurs when in_valid && in_ready. Transfer out occurs when out_valid && out_ready.
- When advancing without an input transfer, stage 0 loads valid = 0 (bubble). Bubbles are not collapsed.
- Data registers of invalid stages are don't-care internally, but the output registers are only updated when a valid result enters the last stage.
- Arithmetic: {c_out, sum} = a + b + c_in, computed modulo 2^WIDTH with a true carry chain across chunks.
- Reset (rst_n = 0, any time including mid-operation):
  - Clears all valid bits immediately.
  - sum = 0, c_out = 0, ovf = 0, out_valid = 0.
  - in_ready becomes 1, since out_valid = 0.
  - In-flight operations are discarded.

## Timing
- Latency: STAGES cycles. Operands accepted at edge T give out_valid = 1 after edge T+STAGES-1, i.e. visible during cycle T+STAGES-1 to T+STAGES.
- Throughput: one operation per cycle while out_ready = 1.
- Stall: while out_valid && !out_ready:
  - Every stage holds.
  - sum, c_out and ovf are stable.
  - in_ready = 0.
- A simultaneous output transfer and input transfer in the same cycle is legal and loses no data.
- STAGES = 1: a single registered full-width ripple adder with the same handshake.
- With a full pipeline and out_ready toggling, no result may be duplicated or dropped.

## Configuration
- PIPELINED_ADDER_SUB_EN defined:
  - Port sub exists and is captured with the operands.
  - When sub = 1, stage logic uses ~b and forces the carry-in to 1, computing a - b. c_in is ignored in this case.
  - c_out = 1 means no borrow.
  - ovf is the signed subtraction overflow.
  - When sub = 0, behaviour is identical to add.
- Not defined: the sub port is absent and the block performs addition only. Area is reduced by the XOR row.

## Test plan
- WIDTH=16, STAGES=4; a=0x00FF, b=0x0001, c_in=0 -> sum=0x0100, c_out=0, ovf=0, out_valid rises 4 edges after acceptance. This checks carry crossing a chunk boundary.
- a=0xFFFF, b=0x0000, c_in=1 -> sum=0x0000, c_out=1, ovf=0. This checks a carry rippling through all stages.
- a=0x7FFF, b=0x0001, c_in=0 -> sum=0x8000, c_out=0, ovf=1.
- Stream 6 back-to-back operations (a=i, b=0x1000*i); hold out_ready=0 for 3 cycles mid-stream:
  - in_ready = 0 during the hold.
  - Outputs stay frozen during the hold.
  - All 6 results arrive in order, exactly once.
- Accept 2 operations, then assert rst_n=0 asynchronously between edges:
  - out_valid and sum go to 0 without a clock edge.
  - After release, no stale result appears.
- With PIPELINED_ADDER_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, c_out=0, ovf=0. Also a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, c_out=1, ovf=1.
